draw_sequencer: RTL

- Parametrised frame scheduler and VGA write multiplexer for the game top level.
- Generates the frame-rate tick and enables NUM_LAYERS drawing engines (map, link, enemies, ...) one at a time, in fixed index order, once per frame.
- Registers the active engine's pixel stream to the VGA adapter.
- Adds what the per-game datapath mux lacked: a layer-count parameter, a per-layer watchdog, frame-overrun detection and sticky error flags.

---
 rtl/draw_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/draw_sequencer.sv
// Frame scheduler and VGA write multiplexer: ticks once per frame, enables each
// drawing layer in index order, and registers the active layer's pixels to the VGA port.
module draw_sequencer #(
  parameter int unsigned NUM_LAYERS  = 3,
  parameter int unsigned LAYER_W     = 2,
  parameter int unsigned X_W         = 9,
  parameter int unsigned Y_W         = 8,
  parameter int unsigned C_W         = 6,
  parameter int unsigned FRAME_COUNT = 1000000,
  parameter int unsigned CNT_W       = 21,
  parameter int unsigned TIMEOUT     = 200000,
  parameter int unsigned TO_W        = 18
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear_err,
  input  logic [NUM_LAYERS-1:0]     layer_done,
  input  logic [NUM_LAYERS-1:0]     layer_write,
  input  logic [NUM_LAYERS*X_W-1:0] layer_x,
  input  logic [NUM_LAYERS*Y_W-1:0] layer_y,
  input  logic [NUM_LAYERS*C_W-1:0] layer_colour,
  output logic [NUM_LAYERS-1:0]     layer_en,
  output logic [LAYER_W-1:0]        active_layer,
  output logic                      frame_tick,
  output logic                      frame_busy,
  output logic [X_W-1:0]            x_position,
  output logic [Y_W-1:0]            y_position,
  output logic [C_W-1:0]            colour,
  output logic                      VGA_enable,
  output logic                      overrun,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {IDLE, DRAW, GAP} state_t;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FRAME_COUNT - 1);
  localparam logic [TO_W-1:0]    WD_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);

  state_t                  state, state_nxt;
  logic [LAYER_W-1:0]      layer_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [TO_W-1:0]         wd, wd_nxt;
  logic [NUM_LAYERS-1:0]   en_nxt;
  logic                    ov_set, to_set;
  logic                    sel_done, sel_write;
  logic [X_W-1:0]          sel_x;
  logic [Y_W-1:0]          sel_y;
  logic [C_W-1:0]          sel_c;

  // Pick out the active layer's handshake and pixel fields.
  always_comb begin
    sel_done  = 1'b0;
    sel_write = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_c     = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (active_layer == LAYER_W'(i)) begin
        sel_done  = layer_done[i];
        sel_write = layer_write[i];
        sel_x     = layer_x[i*X_W +: X_W];
        sel_y     = layer_y[i*Y_W +: Y_W];
        sel_c     = layer_colour[i*C_W +: C_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Layer sequencing; ticks seen while a frame is in flight are dropped as overruns.
  always_comb begin
    state_nxt = state;
    layer_nxt = active_layer;
    wd_nxt    = '0;
    ov_set    = 1'b0;
    to_set    = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      layer_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_tick) begin
            state_nxt = DRAW;
            layer_nxt = '0;
          end
        end
        DRAW: begin
          ov_set = frame_tick;
          if (sel_done) begin
            state_nxt = GAP;
          end else if (wd == WD_LAST) begin
            state_nxt = GAP;
            to_set    = 1'b1;
          end else begin
            wd_nxt = wd + TO_W'(1);
          end
        end
        GAP: begin
          ov_set = frame_tick;
          if (active_layer == LAYER_LAST) begin
            state_nxt = IDLE;
            layer_nxt = '0;
          end else begin
            state_nxt = DRAW;
            layer_nxt = active_layer + LAYER_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      en_nxt[i] = (state_nxt == DRAW) && (layer_nxt == LAYER_W'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      frame_tick   <= 1'b0;
      active_layer <= '0;
      wd           <= '0;
      layer_en     <= '0;
      frame_busy   <= 1'b0;
      x_position   <= '0;
      y_position   <= '0;
      colour       <= '0;
      VGA_enable   <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (!enable) begin
        cnt        <= '0;
        frame_tick <= 1'b0;
      end else if (cnt == CNT_LAST) begin
        cnt        <= '0;
        frame_tick <= 1'b1;
      end else begin
        cnt        <= cnt + CNT_W'(1);
        frame_tick <= 1'b0;
      end
      active_layer <= layer_nxt;
      wd           <= wd_nxt;
      layer_en     <= en_nxt;
      frame_busy   <= (state_nxt != IDLE);
      VGA_enable   <= enable && (state == DRAW) && sel_write && !sel_done;
      if (enable && (state == DRAW)) begin
        x_position <= sel_x;
        y_position <= sel_y;
        colour     <= sel_c;
      end
      // A new error event takes priority over a simultaneous clear.
      overrun     <= ov_set | (overrun & ~clear_err);
      timeout_err <= to_set | (timeout_err & ~clear_err);
    end
  end

endmodule
